mure_retire_sequencer: RTL and testbench

//  Serialises multi-retirement groups into the single-instruction stream consumed by the trace encoder.

---
 rtl/mure_pkg.sv | 28 ++
 rtl/mure_lane_picker.sv | 26 ++
 rtl/mure_retire_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_mure_retire_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mure_pkg.sv
// Shared types and widths for the multi-retire sequencer slice.
package mure_pkg;

    localparam int unsigned XLEN             = 32;
    localparam int unsigned INST_LEN         = 32;
    localparam int unsigned CAUSE_LEN        = 5;
    localparam int unsigned NR_RETIRED_INSTR = 2;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        TRAP
    } seq_state_e;

    // The valids field is sized by NR_RETIRED_INSTR; the top's lane parameter must match it.
    typedef struct packed {
        logic [NR_RETIRED_INSTR-1:0] valids;
        logic                        exception;
        logic                        eret;
        logic [CAUSE_LEN-1:0]        cause;
        logic [XLEN-1:0]             tval;
    } seq_group_s;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mure_lane_picker.sv
// Find-first-set over the remaining lane mask; is_last flags the final lane still pending.
module mure_lane_picker
    import mure_pkg::*;
#(
    parameter int unsigned NrLanes = 2,
    localparam int unsigned IdxW   = idx_width(NrLanes)
) (
    input  logic [NrLanes-1:0] mask_i,
    output logic [IdxW-1:0]    idx_o,
    output logic               found_o,
    output logic               is_last_o
);

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int unsigned i = 0; i < NrLanes; i++) begin
            if (mask_i[i] && !found_o) begin
                idx_o   = IdxW'(i);
                found_o = 1'b1;
            end
        end
        is_last_o = found_o && ((mask_i & ~(NrLanes'(1) << idx_o)) == '0);
    end

endmodule

// File: rtl/mure_retire_sequencer.sv
// Serialises retirement groups into one record per handshake, followed by an optional trap record.
// Optional stall counter enabled by defining MURE_SEQ_STALL_CNT_EN.
module mure_retire_sequencer
    import mure_pkg::*;
#(
    parameter int unsigned NrRetiredInstr = NR_RETIRED_INSTR
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               grp_valid_i,
    output logic                               grp_pop_o,
    input  logic [NrRetiredInstr-1:0]          grp_valids_i,
    input  logic                               grp_exception_i,
    input  logic                               grp_eret_i,
    input  logic [CAUSE_LEN-1:0]               grp_cause_i,
    input  logic [XLEN-1:0]                    grp_tval_i,
    input  logic [NrRetiredInstr-1:0]          lane_empty_i,
    output logic [NrRetiredInstr-1:0]          lane_pop_o,
    input  logic [NrRetiredInstr*INST_LEN-1:0] lane_uop_i,
    input  logic [NrRetiredInstr*XLEN-1:0]     lane_pc_i,
    output logic                               inst_valid_o,
    input  logic                               inst_ready_i,
    output logic                               iretired_o,
    output logic                               exception_o,
    output logic                               interrupt_o,
    output logic                               eret_o,
    output logic [INST_LEN-1:0]                inst_data_o,
    output logic [XLEN-1:0]                    pc_o,
    output logic [XLEN-1:0]                    epc_o,
    output logic [CAUSE_LEN-1:0]               cause_o,
    output logic [XLEN-1:0]                    tval_o,
    output logic [31:0]                        stall_cnt_o
);

    localparam int unsigned IdxW = idx_width(NrRetiredInstr);

    seq_state_e                state_q, state_d;
    seq_group_s                grp_q, grp_d;
    logic [XLEN-1:0]           epc_q, epc_d;
    logic [NrRetiredInstr-1:0] mask;
    logic [IdxW-1:0]           idx;
    logic                      found;
    logic                      is_last;
    logic                      lane_rdy;
    logic [INST_LEN-1:0]       head_uop;
    logic [XLEN-1:0]           head_pc;

    assign mask     = NrRetiredInstr'(grp_q.valids);
    assign lane_rdy = found && !lane_empty_i[idx];
    assign head_uop = lane_uop_i[32'(idx) * INST_LEN +: INST_LEN];
    assign head_pc  = lane_pc_i[32'(idx) * XLEN +: XLEN];

    mure_lane_picker #(
        .NrLanes (NrRetiredInstr)
    ) u_picker (
        .mask_i    (mask),
        .idx_o     (idx),
        .found_o   (found),
        .is_last_o (is_last)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grp_q   <= '0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            epc_q   <= epc_d;
        end
    end

    // Next state, group latch and epc update.
    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        epc_d   = epc_q;
        case (state_q)
            IDLE: begin
                if (grp_valid_i) begin
                    grp_d.valids    = NR_RETIRED_INSTR'(grp_valids_i);
                    grp_d.exception = grp_exception_i;
                    grp_d.eret      = grp_eret_i;
                    grp_d.cause     = grp_cause_i;
                    grp_d.tval      = grp_tval_i;
                    if (grp_valids_i != '0) begin
                        state_d = EMIT;
                    end else if (grp_exception_i) begin
                        state_d = TRAP;
                    end
                end
            end
            EMIT: begin
                if (!found) begin
                    state_d = IDLE;
                end else if (lane_rdy && inst_ready_i) begin
                    epc_d             = head_pc;
                    grp_d.valids[idx] = 1'b0;
                    if (!is_last) begin
                        state_d = EMIT;
                    end else if (grp_q.exception) begin
                        state_d = TRAP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            TRAP: begin
                if (inst_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Record outputs decoded from registered state and lane FIFO heads.
    always_comb begin
        grp_pop_o    = 1'b0;
        lane_pop_o   = '0;
        inst_valid_o = 1'b0;
        iretired_o   = 1'b0;
        exception_o  = 1'b0;
        interrupt_o  = 1'b0;
        eret_o       = 1'b0;
        inst_data_o  = '0;
        pc_o         = '0;
        cause_o      = '0;
        tval_o       = '0;
        epc_o        = epc_q;
        case (state_q)
            IDLE: begin
                grp_pop_o = grp_valid_i && !rst_i;
            end
            EMIT: begin
                inst_valid_o = lane_rdy;
                if (lane_rdy) begin
                    iretired_o      = 1'b1;
                    inst_data_o     = head_uop;
                    pc_o            = head_pc;
                    eret_o          = is_last && grp_q.eret;
                    lane_pop_o[idx] = inst_ready_i;
                end
            end
            TRAP: begin
                inst_valid_o = 1'b1;
                exception_o  = 1'b1;
                interrupt_o  = grp_q.cause[CAUSE_LEN-1];
                cause_o      = grp_q.cause;
                tval_o       = grp_q.tval;
            end
            default: ;
        endcase
    end

`ifdef MURE_SEQ_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        stall;

    // Backpressure or lane underrun; saturating.
    always_comb begin
        stall       = (inst_valid_o && !inst_ready_i) || (state_q == EMIT && !lane_rdy);
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mure_retire_sequencer.sv
// Scoreboard bench for mure_retire_sequencer: directed scenarios followed by randomized groups.
module tb_mure_retire_sequencer;
    import mure_pkg::*;

    localparam int unsigned NL = 2;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     grp_valid_i = 1'b0;
    logic                     grp_pop_o;
    logic [NL-1:0]            grp_valids_i = '0;
    logic                     grp_exception_i = 1'b0;
    logic                     grp_eret_i = 1'b0;
    logic [CAUSE_LEN-1:0]     grp_cause_i = '0;
    logic [XLEN-1:0]          grp_tval_i = '0;
    logic [NL-1:0]            lane_empty_i = '1;
    logic [NL-1:0]            lane_pop_o;
    logic [NL*INST_LEN-1:0]   lane_uop_i = '0;
    logic [NL*XLEN-1:0]       lane_pc_i = '0;
    logic                     inst_valid_o;
    logic                     inst_ready_i = 1'b0;
    logic                     iretired_o, exception_o, interrupt_o, eret_o;
    logic [INST_LEN-1:0]      inst_data_o;
    logic [XLEN-1:0]          pc_o, epc_o, tval_o;
    logic [CAUSE_LEN-1:0]     cause_o;
    logic [31:0]              stall_cnt_o;

    always #5 clk = ~clk;

    mure_retire_sequencer #(.NrRetiredInstr(NL)) dut (
        .clk_i(clk), .rst_i(rst),
        .grp_valid_i(grp_valid_i), .grp_pop_o(grp_pop_o),
        .grp_valids_i(grp_valids_i), .grp_exception_i(grp_exception_i),
        .grp_eret_i(grp_eret_i), .grp_cause_i(grp_cause_i), .grp_tval_i(grp_tval_i),
        .lane_empty_i(lane_empty_i), .lane_pop_o(lane_pop_o),
        .lane_uop_i(lane_uop_i), .lane_pc_i(lane_pc_i),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
        .iretired_o(iretired_o), .exception_o(exception_o), .interrupt_o(interrupt_o),
        .eret_o(eret_o), .inst_data_o(inst_data_o), .pc_o(pc_o), .epc_o(epc_o),
        .cause_o(cause_o), .tval_o(tval_o), .stall_cnt_o(stall_cnt_o)
    );

    typedef struct {
        bit                   retired;
        bit                   intr;
        bit                   eret;
        logic [INST_LEN-1:0]  data;
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      epc;
        logic [CAUSE_LEN-1:0] cause;
        logic [XLEN-1:0]      tval;
        int                   lane;
        int                   gid;
    } rec_t;

    typedef struct {
        logic [NL-1:0]        valids;
        bit                   exc;
        bit                   eret;
        logic [CAUSE_LEN-1:0] cause;
        logic [XLEN-1:0]      tval;
    } grp_t;

    typedef struct {
        logic [INST_LEN-1:0] uop;
        logic [XLEN-1:0]     pc;
    } uop_t;

    grp_t            gq[$];
    uop_t            lq[NL][$];
    rec_t            sb[$];
    int              hs_cyc[$];
    int              errors = 0;
    int              checks = 0;
    int              next_gid = 0;
    int              n_acc = 0;
    int              acc_cyc = -1;
    int              cyc = 0;
    logic [XLEN-1:0] m_epc = '0;
    longint          m_stall = 0;
    int              ready_mode = 0;
    logic [NL-1:0]   lane_hide = '0;
    bit              rand_hide = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: a group expands to its set lanes in ascending order, then a trap if flagged.
    task automatic push_group(input logic [NL-1:0] v, input bit exc, input bit eret,
                              input logic [CAUSE_LEN-1:0] cause, input logic [XLEN-1:0] tval,
                              input logic [XLEN-1:0] pc0, input logic [INST_LEN-1:0] uop0,
                              input logic [XLEN-1:0] pc1, input logic [INST_LEN-1:0] uop1);
        grp_t g;
        rec_t r;
        uop_t u;
        int   last;
        g.valids = v; g.exc = exc; g.eret = eret; g.cause = cause; g.tval = tval;
        gq.push_back(g);
        last = -1;
        for (int l = 0; l < NL; l++) if (v[l]) last = l;
        for (int l = 0; l < NL; l++) begin
            if (v[l]) begin
                u.uop = (l == 0) ? uop0 : uop1;
                u.pc  = (l == 0) ? pc0 : pc1;
                lq[l].push_back(u);
                r = '{retired: 1'b1, intr: 1'b0, eret: (eret && l == last), data: u.uop,
                      pc: u.pc, epc: '0, cause: '0, tval: '0, lane: l, gid: next_gid};
                sb.push_back(r);
                m_epc = u.pc;
            end
        end
        if (exc) begin
            r = '{retired: 1'b0, intr: cause[CAUSE_LEN-1], eret: 1'b0, data: '0, pc: '0,
                  epc: m_epc, cause: cause, tval: tval, lane: 0, gid: next_gid};
            sb.push_back(r);
        end
        next_gid++;
    endtask

    task automatic push_random();
        push_group(NL'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0), $urandom_range(0, 1),
                   CAUSE_LEN'($urandom_range(0, 31)), $urandom,
                   {$urandom_range(0, 255), 2'b00}, $urandom, {$urandom_range(0, 255), 2'b00}, $urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() > 0 || gq.size() > 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", (n >= 3000), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int n = 0;
        do begin
            @(negedge clk);
            #3;
            n++;
        end while (!inst_valid_o && n < 50);
        chk("wait_valid_timeout", inst_valid_o, 1);
    endtask

    task automatic check_all_zero(input string name);
        chk(name, {inst_valid_o, grp_pop_o, lane_pop_o, iretired_o, exception_o, interrupt_o,
                   eret_o, inst_data_o, pc_o, epc_o, cause_o, tval_o, stall_cnt_o}, 0);
    endtask

    task automatic check_stall_cnt(input string name, input longint exp);
`ifdef MURE_SEQ_STALL_CNT_EN
        chk(name, stall_cnt_o, exp[31:0]);
`else
        chk(name, stall_cnt_o, 0);
`endif
    endtask

    // Environment: common FIFO and lane FIFOs modelled as queues.
    initial begin
        logic          gp;
        logic [NL-1:0] lp;
        forever begin
            @(negedge clk);
            grp_valid_i = (gq.size() > 0);
            if (gq.size() > 0) begin
                grp_valids_i = gq[0].valids; grp_exception_i = gq[0].exc; grp_eret_i = gq[0].eret;
                grp_cause_i = gq[0].cause; grp_tval_i = gq[0].tval;
            end else begin
                grp_valids_i = '0; grp_exception_i = 1'b0; grp_eret_i = 1'b0;
                grp_cause_i = '0; grp_tval_i = '0;
            end
            for (int l = 0; l < NL; l++) begin
                lane_empty_i[l] = (lq[l].size() == 0) || lane_hide[l] ||
                                  (rand_hide && $urandom_range(0, 3) == 0);
                lane_uop_i[l*INST_LEN +: INST_LEN] = (lq[l].size() > 0) ? lq[l][0].uop : '0;
                lane_pc_i[l*XLEN +: XLEN]          = (lq[l].size() > 0) ? lq[l][0].pc : '0;
            end
            inst_ready_i = (ready_mode == 0) ? 1'b1 :
                           (ready_mode == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
            #3;
            gp = grp_pop_o;
            lp = lane_pop_o;
            if (gp) chk("grp_pop_nonempty", (gq.size() > 0), 1);
            @(posedge clk);
            if (gp && gq.size() > 0) begin
                void'(gq.pop_front());
                n_acc++;
                acc_cyc = cyc;
            end
            for (int l = 0; l < NL; l++) if (lp[l] && lq[l].size() > 0) void'(lq[l].pop_front());
        end
    end

    // Monitor: every valid record must match the scoreboard head.
    initial begin
        rec_t          e;
        logic          hs;
        logic [NL-1:0] exp_pop;
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                hs = inst_valid_o && inst_ready_i;
                if (inst_valid_o && !inst_ready_i) m_stall++;
                else if (sb.size() > 0 && sb[0].retired && sb[0].gid < n_acc && lane_empty_i[sb[0].lane])
                    m_stall++;
                if (inst_valid_o) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_record", 1, 0);
                    end else begin
                        e = sb[0];
                        chk("record", {iretired_o, exception_o, interrupt_o, eret_o, inst_data_o, pc_o},
                            {e.retired, !e.retired, e.intr, e.eret, e.data, e.pc});
                        if (!e.retired) chk("trap_info", {epc_o, cause_o, tval_o}, {e.epc, e.cause, e.tval});
                        exp_pop = (hs && e.retired) ? NL'(1 << e.lane) : '0;
                        chk("lane_pop", lane_pop_o, exp_pop);
                        if (hs) begin
                            void'(sb.pop_front());
                            hs_cyc.push_back(cyc);
                        end
                    end
                end else begin
                    chk("no_pop_without_valid", lane_pop_o, 0);
                end
            end
        end
    end

    initial begin
        int b;
        int a0;
        int n;
        repeat (2) @(negedge clk);
        #3;
        check_all_zero("reset_outputs");
        @(negedge clk);
        #1 rst = 1'b0;

        // Two lanes, full throughput.
        @(posedge clk);
        #1;
        b  = hs_cyc.size();
        a0 = n_acc;
        push_group(2'b11, 1'b0, 1'b0, '0, '0, 32'h1000, 32'h0000_0013, 32'h1004, 32'h0010_0093);
        drain();
        chk("t1_grp_pops", n_acc - a0, 1);
        chk("t1_records", hs_cyc.size() - b, 2);
        if (hs_cyc.size() - b == 2) begin
            chk("t1_first_latency", hs_cyc[b] - acc_cyc, 1);
            chk("t1_back_to_back", hs_cyc[b+1] - hs_cyc[b], 1);
        end

        // Retire lane 1 then exception trap.
        push_group(2'b10, 1'b1, 1'b0, 5'h02, 32'hdead, '0, '0, 32'h2000, 32'h0000_0073);
        drain();

        // Interrupt with no retiring lanes.
        push_group(2'b00, 1'b1, 1'b0, 5'h13, 32'h0000_0bad, '0, '0, '0, '0);
        drain();
        check_stall_cnt("stall_cnt_none", 0);

        // Backpressure for three cycles on the first record.
        ready_mode = 2;
        push_group(2'b01, 1'b0, 1'b1, '0, '0, 32'h3000, 32'h3020_0073, '0, '0);
        wait_valid();
        @(negedge clk);
        #1;
        @(negedge clk);
        #1 ready_mode = 0;
        drain();
        check_stall_cnt("stall_cnt_three", 3);

        // Lane 0 underrun for two cycles after accept.
        lane_hide = 2'b01;
        a0 = n_acc;
        push_group(2'b01, 1'b0, 1'b0, '0, '0, 32'h4000, 32'h0000_1111, '0, '0);
        n = 0;
        while (n_acc == a0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t5_accept_timeout", (n >= 50), 0);
        repeat (2) begin
            @(negedge clk);
            #3;
            chk("underrun_hold", {inst_valid_o, lane_pop_o}, 0);
        end
        #1 lane_hide = '0;
        drain();
        check_stall_cnt("stall_cnt_underrun", 5);

        // Reset in the middle of a two-lane group.
        ready_mode = 2;
        push_group(2'b11, 1'b0, 1'b0, '0, '0, 32'h5000, 32'h5555, 32'h5004, 32'h6666);
        wait_valid();
        @(negedge clk);
        #1 rst = 1'b1;
        gq.delete();
        for (int l = 0; l < NL; l++) lq[l].delete();
        sb.delete();
        m_epc = '0; m_stall = 0; next_gid = 0; n_acc = 0;
        #2;
        check_all_zero("mid_group_reset");
        @(negedge clk);
        #1 rst = 1'b0;
        ready_mode = 0;
        @(posedge clk);
        #1;
        push_group(2'b11, 1'b1, 1'b0, 5'h07, 32'h77, 32'h6000, 32'h0000_aaaa, 32'h6004, 32'h0000_bbbb);
        drain();
        check_stall_cnt("stall_cnt_after_reset", 0);

        // Randomized groups with random backpressure and underruns.
        ready_mode = 1;
        rand_hide  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            n = 0;
            while (gq.size() > 2 && n < 500) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (n >= 500) chk("feed_timeout", 1, 0);
            push_random();
        end
        drain();
        rand_hide = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_stall_cnt("stall_cnt_random", m_stall);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
